// File: rtl/clock_disp_scan.sv
// Purpose: time-multiplexed 6-digit seven-segment scan with per-frame snapshot, blink, LZB and dp.
// Latency: outputs decode registered state only; frame snapshot lands on the edge leaving BLANK of digit 0.
// Backpressure: none; free-running scan, disp_en only gates the outputs dark.
module clock_disp_scan #(
  parameter int SCAN_DIV   = 2,
  parameter int BLINK_HALF = 500,
  parameter int LZB        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  input  logic [3:0] d5,
  input  logic [5:0] blink_mask,
  input  logic [5:0] dp_mask,
  input  logic       disp_en,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] dig_sel,
  output logic       frame_start
);

  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  typedef enum logic {ST_BLANK, ST_ON} phase_t;

  // One frame's worth of display content, frozen so a digit never tears mid-frame.
  typedef struct packed {
    logic [5:0][3:0] d;
    logic [5:0]      blink;
    logic [5:0]      dp;
  } snap_t;

  phase_t        phase;
  logic [2:0]    idx;
  logic [TW-1:0] tcnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  snap_t         snap;

  logic [3:0]    cur_d;
  logic          cur_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b1000000;
    endcase
    return s;
  endfunction

  // Scan FSM: one blank slot then SCAN_DIV on cycles per digit; snapshot taken leaving blank of digit 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= ST_BLANK;
      idx   <= 3'd0;
      tcnt  <= '0;
      snap  <= '0;
    end else begin
      case (phase)
        ST_BLANK: begin
          phase <= ST_ON;
          tcnt  <= '0;
          if (idx == 3'd0) begin
            snap.d     <= {d5, d4, d3, d2, d1, d0};
            snap.blink <= blink_mask;
            snap.dp    <= dp_mask;
          end
        end
        default: begin
          if (tcnt == TW'(SCAN_DIV - 1)) begin
            phase <= ST_BLANK;
            idx   <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Free-running blink timebase, independent of the scan and of disp_en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Per-digit blank: blinking digit in its off half, or a zero hour-tens under leading-zero blanking.
  always_comb begin
    cur_d     = snap.d[idx];
    cur_blank = (snap.blink[idx] && blink_phase) ||
                ((LZB != 0) && (idx == 3'd5) && (snap.d[5] == 4'd0));
  end

  // Output decode from registered state; disp_en is the only live gate.
  always_comb begin
    seg         = 7'd0;
    dp          = 1'b0;
    dig_sel     = 6'd0;
    frame_start = (phase == ST_BLANK) && (idx == 3'd0);
    if (disp_en && (phase == ST_ON)) begin
      dig_sel = 6'b000001 << idx;
      if (!cur_blank) begin
        seg = seg_decode(cur_d);
        dp  = snap.dp[idx];
      end
    end
  end

endmodule
